// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// mips_cpu_pkg : opcode/funct/regimm encodings, FSM state type, reset vector
// Revision     : 1.0
// ============================================================================
package mips_cpu_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [4:0] RI_BLTZ = 5'h00;
    localparam logic [4:0] RI_BGEZ = 5'h01;

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_EXEC       = 3'd2,
        S_MEM        = 3'd3,
        S_MEM_WAIT   = 3'd4,
        S_WB         = 3'd5,
        S_HALTED     = 3'd6
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_regfile.sv
`default_nettype none
// ============================================================================
// mips_cpu_regfile : 32x32 GPR file, two async reads, one sync write, $0 = 0
// Revision         : 1.0
// ============================================================================
module mips_cpu_regfile
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra_i,
    input  logic [4:0]  rb_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_a_o,
    output logic [31:0] rd_b_o,
    output logic [31:0] v0_o
);

    logic [31:0] regs_q [0:31];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd_a_o = (ra_i == 5'd0) ? 32'd0 : regs_q[ra_i];
    assign rd_b_o = (rb_i == 5'd0) ? 32'd0 : regs_q[rb_i];
    assign v0_o   = regs_q[2];

endmodule
`default_nettype wire

// File: rtl/mips_cpu_bus_core.sv
`default_nettype none
// ============================================================================
// mips_cpu_bus_core : multicycle MIPS-I core on a single Avalon-style bus
// Revision          : 1.0
// ============================================================================
module mips_cpu_bus_core
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    state_t      state_q;
    logic [31:0] pc_q, npc_q, ir_q, result_q, target_q, maddr_q;
    logic [31:0] address_q, writedata_q;
    logic [3:0]  byteenable_q, st_be_q;
    logic [4:0]  dst_q;
    logic [1:0]  lane_q;
    logic        wen_q, taken_q, is_load_q, is_store_q;
    logic        read_q, write_q, active_q;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rs_val, rt_val, simm, zimm, pc4, link, br_tgt, j_tgt, ea;

    assign op     = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign simm   = sext16(ir_q[15:0]);
    assign zimm   = {16'd0, ir_q[15:0]};
    assign pc4    = pc_q + 32'd4;
    assign link   = pc_q + 32'd8;
    assign br_tgt = pc4 + {simm[29:0], 2'b00};
    assign j_tgt  = {pc4[31:28], ir_q[25:0], 2'b00};
    assign ea     = rs_val + simm;

    mips_cpu_regfile u_regfile (
        .clk    (clk),
        .reset  (reset),
        .ra_i   (rs),
        .rb_i   (rt),
        .we_i   ((state_q == S_WB) && wen_q),
        .wa_i   (dst_q),
        .wd_i   (result_q),
        .rd_a_o (rs_val),
        .rd_b_o (rt_val),
        .v0_o   (register_v0)
    );

    logic [31:0] res_d, target_d;
    logic [4:0]  dst_d;
    logic        wen_d, taken_d, load_d, store_d;

    always_comb begin
        res_d    = '0;
        dst_d    = rt;
        wen_d    = 1'b0;
        taken_d  = 1'b0;
        target_d = br_tgt;
        load_d   = 1'b0;
        store_d  = 1'b0;
        case (op)
            OP_SPECIAL: begin
                dst_d = rd;
                wen_d = 1'b1;
                case (funct)
                    F_SLL:  res_d = rt_val << shamt;
                    F_SRL:  res_d = rt_val >> shamt;
                    F_SRA:  res_d = $unsigned($signed(rt_val) >>> shamt);
                    F_SLLV: res_d = rt_val << rs_val[4:0];
                    F_SRLV: res_d = rt_val >> rs_val[4:0];
                    F_SRAV: res_d = $unsigned($signed(rt_val) >>> rs_val[4:0]);
                    F_JR: begin
                        wen_d    = 1'b0;
                        taken_d  = 1'b1;
                        target_d = rs_val;
                    end
                    F_JALR: begin
                        taken_d  = 1'b1;
                        target_d = rs_val;
                        res_d    = link;
                    end
                    F_ADDU: res_d = rs_val + rt_val;
                    F_SUBU: res_d = rs_val - rt_val;
                    F_AND:  res_d = rs_val & rt_val;
                    F_OR:   res_d = rs_val | rt_val;
                    F_XOR:  res_d = rs_val ^ rt_val;
                    F_NOR:  res_d = ~(rs_val | rt_val);
                    F_SLT:  res_d = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    F_SLTU: res_d = {31'd0, rs_val < rt_val};
                    default: wen_d = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RI_BLTZ: taken_d = rs_val[31];
                    RI_BGEZ: taken_d = ~rs_val[31];
                    default: taken_d = 1'b0;
                endcase
            end
            OP_J: begin
                taken_d  = 1'b1;
                target_d = j_tgt;
            end
            OP_JAL: begin
                taken_d  = 1'b1;
                target_d = j_tgt;
                wen_d    = 1'b1;
                dst_d    = 5'd31;
                res_d    = link;
            end
            OP_BEQ:   taken_d = (rs_val == rt_val);
            OP_BNE:   taken_d = (rs_val != rt_val);
            OP_BLEZ:  taken_d = rs_val[31] || (rs_val == 32'd0);
            OP_BGTZ:  taken_d = !rs_val[31] && (rs_val != 32'd0);
            OP_ADDIU: begin wen_d = 1'b1; res_d = rs_val + simm; end
            OP_SLTI:  begin wen_d = 1'b1; res_d = {31'd0, $signed(rs_val) < $signed(simm)}; end
            OP_SLTIU: begin wen_d = 1'b1; res_d = {31'd0, rs_val < simm}; end
            OP_ANDI:  begin wen_d = 1'b1; res_d = rs_val & zimm; end
            OP_ORI:   begin wen_d = 1'b1; res_d = rs_val | zimm; end
            OP_XORI:  begin wen_d = 1'b1; res_d = rs_val ^ zimm; end
            OP_LUI:   begin wen_d = 1'b1; res_d = {ir_q[15:0], 16'd0}; end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                wen_d  = 1'b1;
                load_d = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: store_d = 1'b1;
            default: ;
        endcase
    end

    // Narrow stores replicate their data so the lane selected by byteenable is always valid.
    logic [31:0] st_data;
    logic [3:0]  st_be;
    always_comb begin
        st_data = rt_val;
        st_be   = 4'b1111;
        case (op)
            OP_SB: begin
                st_data = {4{rt_val[7:0]}};
                st_be   = 4'b0001 << ea[1:0];
            end
            OP_SH: begin
                st_data = {2{rt_val[15:0]}};
                st_be   = ea[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = readdata[7:0];
            2'd1:    ld_byte = readdata[15:8];
            2'd2:    ld_byte = readdata[23:16];
            default: ld_byte = readdata[31:24];
        endcase
        ld_half = lane_q[1] ? readdata[31:16] : readdata[15:0];
        case (op)
            OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_val = {24'd0, ld_byte};
            OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_val = {16'd0, ld_half};
            default: ld_val = readdata;
        endcase
    end

    // Request states raise the strobe on entry, then wait for waitrequest=0 to drop it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_VECTOR;
            npc_q        <= RESET_VECTOR + 32'd4;
            ir_q         <= '0;
            result_q     <= '0;
            target_q     <= '0;
            maddr_q      <= '0;
            dst_q        <= '0;
            lane_q       <= '0;
            wen_q        <= 1'b0;
            taken_q      <= 1'b0;
            is_load_q    <= 1'b0;
            is_store_q   <= 1'b0;
            st_be_q      <= '0;
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            active_q     <= 1'b1;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!read_q) begin
                        if (pc_q == HALT_ADDR) begin
                            state_q  <= S_HALTED;
                            active_q <= 1'b0;
                        end else begin
                            read_q       <= 1'b1;
                            address_q    <= pc_q;
                            byteenable_q <= 4'b1111;
                        end
                    end else if (!waitrequest) begin
                        read_q       <= 1'b0;
                        byteenable_q <= 4'b0000;
                        state_q      <= S_FETCH_WAIT;
                    end
                end
                S_FETCH_WAIT: begin
                    ir_q    <= readdata;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    result_q    <= res_d;
                    dst_q       <= dst_d;
                    wen_q       <= wen_d;
                    taken_q     <= taken_d;
                    target_q    <= target_d;
                    is_load_q   <= load_d;
                    is_store_q  <= store_d;
                    lane_q      <= ea[1:0];
                    maddr_q     <= {ea[31:2], 2'b00};
                    writedata_q <= st_data;
                    st_be_q     <= st_be;
                    state_q     <= (load_d || store_d) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (!(read_q || write_q)) begin
                        address_q    <= maddr_q;
                        read_q       <= is_load_q;
                        write_q      <= is_store_q;
                        byteenable_q <= is_store_q ? st_be_q : 4'b1111;
                    end else if (!waitrequest) begin
                        read_q       <= 1'b0;
                        write_q      <= 1'b0;
                        byteenable_q <= 4'b0000;
                        state_q      <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (is_load_q) begin
                        result_q <= ld_val;
                    end
                    state_q <= S_WB;
                end
                S_WB: begin
                    pc_q    <= npc_q;
                    npc_q   <= taken_q ? target_q : (npc_q + 32'd4);
                    state_q <= S_FETCH;
                end
                default: state_q <= S_HALTED;
            endcase
        end
    end

    assign active     = active_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mips_cpu_bus_core : directed program vectors against a stalling bus memory
// Revision             : 1.0
// ============================================================================
module tb_mips_cpu_bus_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active, read, write;
    logic        waitrequest = 1'b1;
    logic [31:0] register_v0, address, writedata;
    logic [31:0] readdata = 32'd0;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    mips_cpu_bus_core dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    // 256-byte memory window at 0xBFC00000; everything else reads as 0.
    logic [31:0] mem [0:63];
    int          stall = 0;
    int          wait_cnt = 0, req_cnt = 0, wr_cnt = 0, stab_err = 0, both_err = 0;
    logic        held = 1'b0, acc_pend = 1'b0, acc_we = 1'b0, h_rd = 1'b0;
    logic [31:0] acc_addr = 0, acc_wd = 0, h_addr = 0, h_wd = 0, last_addr = 0, last_wd = 0;
    logic [3:0]  acc_be = 0, h_be = 0, last_be = 0;
    int          total = 0, bad = 0;

    function automatic logic [31:0] mrd(input logic [31:0] a);
        if (a[31:8] == 24'hBFC000) return mem[a[7:2]];
        return 32'd0;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            wait_cnt    = 0;
            acc_pend    = 1'b0;
            held        = 1'b0;
            waitrequest = 1'b1;
        end else begin
            if (acc_pend) begin
                if (acc_we) begin
                    if (acc_addr[31:8] == 24'hBFC000) begin
                        for (int b = 0; b < 4; b++)
                            if (acc_be[b]) mem[acc_addr[7:2]][8*b +: 8] = acc_wd[8*b +: 8];
                    end
                    wr_cnt++;
                    last_addr = acc_addr;
                    last_be   = acc_be;
                    last_wd   = acc_wd;
                end else begin
                    readdata = mrd(acc_addr);
                end
                acc_pend = 1'b0;
            end else begin
                readdata = 32'hDEADBEEF;
            end
            if (read || write) begin
                if (read && write) both_err++;
                if (held && (address != h_addr || byteenable != h_be || writedata != h_wd || read != h_rd))
                    stab_err++;
                if (wait_cnt < stall) begin
                    waitrequest = 1'b1;
                    wait_cnt++;
                    held   = 1'b1;
                    h_addr = address;
                    h_be   = byteenable;
                    h_wd   = writedata;
                    h_rd   = read;
                end else begin
                    waitrequest = 1'b0;
                    wait_cnt    = 0;
                    held        = 1'b0;
                    acc_pend    = 1'b1;
                    acc_we      = write;
                    acc_addr    = address;
                    acc_be      = byteenable;
                    acc_wd      = writedata;
                    req_cnt++;
                end
            end else begin
                waitrequest = 1'b1;
                held        = 1'b0;
                wait_cnt    = 0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [5:0][31:0] prog;
        logic [31:0]      exp;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] w0, w1, w2, w3, w4, w5, ex);
        vec_t v;
        v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2;
        v.prog[3] = w3; v.prog[4] = w4; v.prog[5] = w5;
        v.exp = ex;
        return v;
    endfunction

    task automatic load(input vec_t v);
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        for (int i = 0; i < 6; i++) mem[i] = v.prog[i];
        mem[16] = 32'h8081FF7F;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        req_cnt  = 0;
        wr_cnt   = 0;
        stab_err = 0;
        both_err = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!active) break;
        end
    endtask

    task automatic finish_checks(input string nm);
        int rc;
        check({nm, "_halt"}, {31'd0, active}, 32'd0);
        rc = req_cnt;
        repeat (20) @(negedge clk);
        check({nm, "_quiet"}, req_cnt - rc, 32'd0);
        check({nm, "_bus"}, stab_err + both_err, 32'd0);
    endtask

    task automatic run_prog(input vec_t v, input int st, input string nm);
        load(v);
        stall = st;
        do_reset();
        wait_halt();
        check({nm, "_v0"}, register_v0, v.exp);
        finish_checks(nm);
    endtask

    localparam int NV = 31;
    vec_t vecs [NV];
    logic [31:0] ld_a = 32'h3C08BFC0;
    logic [31:0] ta = 32'h2408FFFB;
    logic [31:0] tb = 32'h24090003;
    logic [31:0] jr0 = 32'h00000008;
    logic [31:0] inc1 = 32'h24420001;
    logic [31:0] inc100 = 32'h24420100;

    initial begin
        int k;
        // loads from word 0x8081FF7F at 0xBFC00040
        vecs[0]  = mk(ld_a, 32'h81020043, jr0, 0, 0, 0, 32'hFFFFFF80);
        vecs[1]  = mk(ld_a, 32'h91020040, jr0, 0, 0, 0, 32'h0000007F);
        vecs[2]  = mk(ld_a, 32'h85020042, jr0, 0, 0, 0, 32'hFFFF8081);
        vecs[3]  = mk(ld_a, 32'h95020040, jr0, 0, 0, 0, 32'h0000FF7F);
        vecs[4]  = mk(ld_a, 32'h8D020040, jr0, 0, 0, 0, 32'h8081FF7F);
        vecs[5]  = mk(32'h24021234, jr0, 0, 0, 0, 0, 32'h00001234);
        // ALU with t0=-5, t1=3
        vecs[6]  = mk(ta, tb, 32'h01091021, jr0, 0, 0, 32'hFFFFFFFE);
        vecs[7]  = mk(ta, tb, 32'h01091023, jr0, 0, 0, 32'hFFFFFFF8);
        vecs[8]  = mk(ta, tb, 32'h01091024, jr0, 0, 0, 32'h00000003);
        vecs[9]  = mk(ta, tb, 32'h01091025, jr0, 0, 0, 32'hFFFFFFFB);
        vecs[10] = mk(ta, tb, 32'h01091026, jr0, 0, 0, 32'hFFFFFFF8);
        vecs[11] = mk(ta, tb, 32'h01091027, jr0, 0, 0, 32'h00000004);
        vecs[12] = mk(ta, tb, 32'h0109102A, jr0, 0, 0, 32'h00000001);
        vecs[13] = mk(ta, tb, 32'h0109102B, jr0, 0, 0, 32'h00000000);
        vecs[14] = mk(ta, tb, 32'h00081100, jr0, 0, 0, 32'hFFFFFFB0);
        vecs[15] = mk(ta, tb, 32'h00081042, jr0, 0, 0, 32'h7FFFFFFD);
        vecs[16] = mk(ta, tb, 32'h00081043, jr0, 0, 0, 32'hFFFFFFFD);
        vecs[17] = mk(ta, tb, 32'h01281004, jr0, 0, 0, 32'hFFFFFFD8);
        vecs[18] = mk(ta, tb, 32'h01281006, jr0, 0, 0, 32'h1FFFFFFF);
        vecs[19] = mk(ta, tb, 32'h01281007, jr0, 0, 0, 32'hFFFFFFFF);
        vecs[20] = mk(ta, tb, 32'h310200F0, jr0, 0, 0, 32'h000000F0);
        vecs[21] = mk(ta, tb, 32'h390280F0, jr0, 0, 0, 32'hFFFF7F0B);
        vecs[22] = mk(ta, tb, 32'h2D22FFFF, jr0, 0, 0, 32'h00000001);
        vecs[23] = mk(ta, tb, 32'h2902FFFC, jr0, 0, 0, 32'h00000001);
        vecs[24] = mk(ta, tb, 32'h3C028001, jr0, 0, 0, 32'h80010000);
        // branches: delay slot adds 1, fall-through adds 0x100
        vecs[25] = mk(32'h24080001, 32'h15000002, inc1, inc100, jr0, 0, 32'h00000001);
        vecs[26] = mk(32'h24080000, 32'h15000002, inc1, inc100, jr0, 0, 32'h00000101);
        vecs[27] = mk(32'h24080000, 32'h11000002, inc1, inc100, jr0, 0, 32'h00000001);
        vecs[28] = mk(32'h24080001, 32'h1D000002, inc1, inc100, jr0, 0, 32'h00000001);
        vecs[29] = mk(32'h24080001, 32'h05000002, inc1, inc100, jr0, 0, 32'h00000101);
        vecs[30] = mk(32'h0FF00003, 32'h03E01021, 32'h2402DEAD, jr0, 0, 0, 32'hBFC00008);

        // reset state and first fetch
        load(vecs[5]);
        stall = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_read", {31'd0, read}, 32'd0);
        check("rst_write", {31'd0, write}, 32'd0);
        check("rst_be", {28'd0, byteenable}, 32'd0);
        check("rst_v0", register_v0, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("active_after_reset", {31'd0, active}, 32'd1);
        k = 0;
        while (!read && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("first_read", {31'd0, read}, 32'd1);
        check("first_addr", address, 32'hBFC00000);
        check("first_be", {28'd0, byteenable}, 32'hF);

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < NV; i++)
                run_prog(vecs[i], s * 5, $sformatf("v%0d_s%0d", i, s * 5));

        // store in the delay slot of jr $0
        for (int s = 0; s < 2; s++) begin
            load(mk(32'h3C08BFC0, 32'h8D09002C, jr0, 32'hA1090032, 0, 0, 0));
            mem[11] = 32'h000000F3;
            stall = s * 5;
            do_reset();
            wait_halt();
            check("sb_count", wr_cnt, 32'd1);
            check("sb_addr", last_addr, 32'hBFC00030);
            check("sb_be", {28'd0, last_be}, 32'h4);
            check("sb_data", last_wd, 32'hF3F3F3F3);
            check("sb_mem", mem[12], 32'h00F30000);
            finish_checks($sformatf("sb_s%0d", s * 5));
        end

        // reset while a fetch is stalled
        load(vecs[6]);
        stall = 5;
        do_reset();
        k = 0;
        while (!(read && address == 32'hBFC00004) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("mid_addr_seen", address, 32'hBFC00004);
        #2 reset = 1'b1;
        #1 check("mid_read_drop", {31'd0, read}, 32'd0);
        check("mid_active", {31'd0, active}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        k = 0;
        while (!read && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("mid_restart_read", {31'd0, read}, 32'd1);
        check("mid_restart_addr", address, 32'hBFC00000);
        wait_halt();
        check("mid_v0", register_v0, 32'hFFFFFFFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
